// File: rtl/relu_quant_pkg.sv
`default_nettype none
// ============================================================================
// Package     : relu_quant_pkg
// Description : Shared widths, lane-slicing helper and mode encoding for the
//               requantizing ReLU/pass activation pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package relu_quant_pkg;

    // Default datapath geometry
    localparam int DEF_DIN_W   = 16;
    localparam int DEF_DOUT_W  = 8;
    localparam int DEF_LANES   = 4;
    localparam int DEF_SHIFT_W = 4;

    // Activation mode encoding carried by cfg_relu
    localparam logic RELU_MODE = 1'b1;
    localparam logic PASS_MODE = 1'b0;

    // LSB position of a lane inside a flattened multi-lane bus
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_quant_lane.sv
`default_nettype none
// ============================================================================
// Module      : relu_quant_lane
// Description : Combinational arithmetic for one lane. The front half does
//               ReLU gating plus arithmetic shift with round-half-up; the
//               back half clamps an already-registered rounded value to the
//               clip range and truncates to the output width.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_quant_lane
    import relu_quant_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    // front half: shift and round
    input  logic [DIN_W-1:0]         i_x,
    input  logic [SHIFT_W-1:0]       i_shift,
    input  logic                     i_relu,
    output logic signed [DIN_W:0]    o_rnd,
    // back half: clamp on the registered value
    input  logic signed [DIN_W:0]    i_rnd_q,
    input  logic                     i_relu_q,
    input  logic [DOUT_W-2:0]        i_clip_q,
    output logic [DOUT_W-1:0]        o_data,
    output logic                     o_sat
);

    logic signed [DIN_W:0]  w_x_ext;
    logic signed [DIN_W:0]  w_shifted;
    logic signed [DIN_W:0]  w_rbit_ext;
    logic [SHIFT_W-1:0]     w_sh_m1;
    logic                   w_rbit;
    logic signed [DIN_W:0]  w_clip_pos;
    logic signed [DIN_W:0]  w_clip_neg;

    // One extra bit of headroom so the +1 rounding carry can never wrap
    assign w_x_ext    = {i_x[DIN_W-1], i_x};
    assign w_shifted  = w_x_ext >>> i_shift;
    assign w_sh_m1    = i_shift - {{(SHIFT_W-1){1'b0}}, 1'b1};
    assign w_rbit     = (i_shift != '0) ? i_x[w_sh_m1] : 1'b0;
    assign w_rbit_ext = {{DIN_W{1'b0}}, w_rbit};

    // ReLU zeroes negative inputs before rounding; otherwise round half up
    always_comb begin
        o_rnd = w_shifted + w_rbit_ext;
        if ((i_relu == RELU_MODE) && i_x[DIN_W-1]) begin
            o_rnd = '0;
        end
    end

    assign w_clip_pos = {{(DIN_W + 2 - DOUT_W){1'b0}}, i_clip_q};
    assign w_clip_neg = -w_clip_pos;

    // Clamp to [0,clip] in ReLU mode or [-clip,clip] in pass mode, then
    // truncate; the clamped value always fits the signed output width
    always_comb begin
        o_data = i_rnd_q[DOUT_W-1:0];
        o_sat  = 1'b0;
        if (i_rnd_q > w_clip_pos) begin
            o_data = w_clip_pos[DOUT_W-1:0];
            o_sat  = 1'b1;
        end else if ((i_relu_q == PASS_MODE) && (i_rnd_q < w_clip_neg)) begin
            o_data = w_clip_neg[DOUT_W-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/relu_quant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : relu_quant_pipe
// Description : Two-stage, multi-lane requantizing activation stage with a
//               full valid/ready handshake. Stage 1 holds the shifted and
//               rounded lanes with the beat's mode and clip; stage 2 holds
//               the clamped result and drives the outputs. Back-pressure
//               stalls the pipe without loss.
//               Optional macro RELU_QUANT_SAT_CNT_EN adds a saturating
//               counter of clamped lanes per output handshake, with the
//               sat_cnt_clr / sat_cnt ports.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_quant_pipe
    import relu_quant_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int LANES   = DEF_LANES,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [LANES*DIN_W-1:0]    in_data,
    input  logic                      cfg_relu,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic [DOUT_W-2:0]         cfg_clip,
`ifdef RELU_QUANT_SAT_CNT_EN
    input  logic                      sat_cnt_clr,
    output logic [15:0]               sat_cnt,
`endif
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [LANES*DOUT_W-1:0]   out_data,
    output logic [LANES-1:0]          out_sat
);

    localparam int c_rnd_w = DIN_W + 1;

    logic                        w_adv1;
    logic                        w_adv2;
    logic [LANES*c_rnd_w-1:0]    w_rnd;
    logic [LANES*DOUT_W-1:0]     w_lane_data;
    logic [LANES-1:0]            w_lane_sat;

    logic                        r_s1_vld;
    logic                        r_s1_relu;
    logic [DOUT_W-2:0]           r_s1_clip;
    logic [LANES*c_rnd_w-1:0]    r_s1_rnd;

    logic                        r_s2_vld;
    logic [LANES*DOUT_W-1:0]     r_s2_data;
    logic [LANES-1:0]            r_s2_sat;

    // A stage advances when it is empty or the stage after it advances
    assign w_adv2 = !r_s2_vld || out_rdy;
    assign w_adv1 = !r_s1_vld || w_adv2;
    assign in_rdy = w_adv1;

    for (genvar i = 0; i < LANES; i++) begin : g_lanes
        relu_quant_lane #(
            .DIN_W   (DIN_W),
            .DOUT_W  (DOUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .i_x      (in_data[lane_lo(i, DIN_W) +: DIN_W]),
            .i_shift  (cfg_shift),
            .i_relu   (cfg_relu),
            .o_rnd    (w_rnd[lane_lo(i, c_rnd_w) +: c_rnd_w]),
            .i_rnd_q  (r_s1_rnd[lane_lo(i, c_rnd_w) +: c_rnd_w]),
            .i_relu_q (r_s1_relu),
            .i_clip_q (r_s1_clip),
            .o_data   (w_lane_data[lane_lo(i, DOUT_W) +: DOUT_W]),
            .o_sat    (w_lane_sat[i])
        );
    end

    // Stage 1: capture rounded lanes plus the beat's mode and clip
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_relu <= PASS_MODE;
            r_s1_clip <= '0;
            r_s1_rnd  <= '0;
        end else if (w_adv1) begin
            r_s1_vld <= in_vld;
            if (in_vld) begin
                r_s1_relu <= cfg_relu;
                r_s1_clip <= cfg_clip;
                r_s1_rnd  <= w_rnd;
            end
        end
    end

    // Stage 2: capture clamped lanes; held stable while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_sat  <= '0;
        end else if (w_adv2) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_data <= w_lane_data;
                r_s2_sat  <= w_lane_sat;
            end
        end
    end

    assign out_vld  = r_s2_vld;
    assign out_data = r_s2_data;
    assign out_sat  = r_s2_sat;

`ifdef RELU_QUANT_SAT_CNT_EN
    logic [16:0] w_sat_sum;
    logic [15:0] r_sat_cnt;

    // Add the number of clamped lanes on each output handshake
    always_comb begin
        w_sat_sum = {1'b0, r_sat_cnt};
        if (r_s2_vld && out_rdy) begin
            for (int i = 0; i < LANES; i++) begin
                w_sat_sum = w_sat_sum + 17'(r_s2_sat[i]);
            end
        end
    end

    // Saturating count; clear has priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || sat_cnt_clr) begin
            r_sat_cnt <= '0;
        end else if (w_sat_sum[16]) begin
            r_sat_cnt <= 16'hFFFF;
        end else begin
            r_sat_cnt <= w_sat_sum[15:0];
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    // Saturation counter not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_relu_quant_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_quant_pipe
// Description : Self-checking bench for relu_quant_pipe. Directed beats,
//               a stalled stream, randomized traffic and a mid-flight reset
//               are checked against an integer-arithmetic reference model
//               through an in-order scoreboard. Counter checks are built
//               when RELU_QUANT_SAT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_quant_pipe;

    localparam int DIN_W   = 16;
    localparam int DOUT_W  = 8;
    localparam int LANES   = 4;
    localparam int SHIFT_W = 4;
    localparam int EW      = LANES*DOUT_W + LANES;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_vld = 1'b0;
    logic                     in_rdy;
    logic [LANES*DIN_W-1:0]   in_data = '0;
    logic                     cfg_relu = 1'b0;
    logic [SHIFT_W-1:0]       cfg_shift = '0;
    logic [DOUT_W-2:0]        cfg_clip = '0;
    logic                     out_vld;
    logic                     out_rdy = 1'b0;
    logic [LANES*DOUT_W-1:0]  out_data;
    logic [LANES-1:0]         out_sat;
`ifdef RELU_QUANT_SAT_CNT_EN
    logic                     sat_cnt_clr = 1'b0;
    logic [15:0]              sat_cnt;
`endif

    always #5 clk = ~clk;

    relu_quant_pipe #(
        .DIN_W   (DIN_W),
        .DOUT_W  (DOUT_W),
        .LANES   (LANES),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_data     (in_data),
        .cfg_relu    (cfg_relu),
        .cfg_shift   (cfg_shift),
        .cfg_clip    (cfg_clip),
`ifdef RELU_QUANT_SAT_CNT_EN
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt),
`endif
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_sat     (out_sat)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic        last_in_hs = 1'b0;
    logic        last_out_hs = 1'b0;
    logic        last_in_rdy = 1'b1;
    logic        stall_prev = 1'b0;
    logic [EW-1:0] hold_prev = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: round-half-up division by 2^sh, then clamp, in plain integers
    function automatic logic [EW-1:0] model(input logic [LANES*DIN_W-1:0] d,
                                            input logic relu, input int sh, input int clip);
        logic [LANES*DOUT_W-1:0] dat;
        logic [LANES-1:0]        sat;
        int                      x;
        int                      r;
        logic [31:0]             rv;
        for (int i = 0; i < LANES; i++) begin
            x      = int'($signed(d[i*DIN_W +: DIN_W]));
            sat[i] = 1'b0;
            if (relu && x < 0)  r = 0;
            else if (sh == 0)   r = x;
            else                r = (x + (1 << (sh - 1))) >>> sh;
            if (r > clip) begin
                r = clip;
                sat[i] = 1'b1;
            end else if (!relu && r < -clip) begin
                r = -clip;
                sat[i] = 1'b1;
            end
            rv = r;
            dat[i*DOUT_W +: DOUT_W] = rv[DOUT_W-1:0];
        end
        return {sat, dat};
    endfunction

    // One clock: observe handshakes away from the edge, then step to negedge
    task automatic cycle();
        #1;
        last_in_rdy = in_rdy;
        last_in_hs  = in_vld && in_rdy && !rst;
        last_out_hs = out_vld && out_rdy && !rst;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("stall_hold", {out_sat, out_data}, hold_prev);
            if (last_out_hs) begin
                chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) chk("beat", {out_sat, out_data}, exp_q.pop_front());
            end
            if (last_in_hs)
                exp_q.push_back(model(in_data, cfg_relu, int'(cfg_shift), int'(cfg_clip)));
            stall_prev = out_vld && !out_rdy;
            hold_prev  = {out_sat, out_data};
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [LANES*DIN_W-1:0] d, input logic relu,
                         input logic [SHIFT_W-1:0] sh, input logic [DOUT_W-2:0] clip);
        in_data = d; cfg_relu = relu; cfg_shift = sh; cfg_clip = clip; in_vld = 1'b1;
    endtask

    task automatic drain();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat into an empty pipe: checks acceptance, 2-cycle latency, value
    task automatic send_single(input logic [LANES*DIN_W-1:0] d, input logic relu,
                               input logic [SHIFT_W-1:0] sh, input logic [DOUT_W-2:0] clip,
                               input logic [EW-1:0] exp_c, input string tag);
        drive(d, relu, sh, clip);
        out_rdy = 1'b1;
        cycle();
        chk({tag, "_acc"}, 64'(last_in_hs), 64'd1);
        in_vld = 1'b0;
        chk({tag, "_lat1"}, 64'(out_vld), 64'd0);
        cycle();
        chk({tag, "_lat2"}, 64'(out_vld), 64'd1);
        chk({tag, "_val"}, {out_sat, out_data}, exp_c);
        cycle();
    endtask

    logic [LANES*DIN_W-1:0] stream_d [8];
    int   sent;
    int   c;
    logic saw_low;

    initial begin
        // Reset and post-reset state
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);

        // Directed beats with hand-derived expectations
        send_single({16'h0430, 16'h0410, 16'h8000, 16'h0800}, 1'b1, 4'd5, 7'h40,
                    {4'b0000, 8'h22, 8'h21, 8'h00, 8'h40}, "relu_sh5");
        send_single({16'hFFD0, 16'hF000, 16'h0FFF, 16'h0000}, 1'b0, 4'd5, 7'h7F,
                    {4'b0110, 8'hFF, 8'h81, 8'h7F, 8'h00}, "pass_sh5");
        send_single({16'h001F, 16'h0021, 16'h7FFF, 16'hFFFF}, 1'b1, 4'd0, 7'h20,
                    {4'b0110, 8'h1F, 8'h20, 8'h20, 8'h00}, "relu_sh0");
        send_single({16'h7FFF, 16'h8000, 16'h4000, 16'hC000}, 1'b0, 4'd15, 7'h7F,
                    {4'b0000, 8'h01, 8'hFF, 8'h01, 8'h00}, "pass_sh15");
        send_single({16'h0001, 16'h0002, 16'hFFFE, 16'h0000}, 1'b0, 4'd2, 7'h00,
                    {4'b0100, 8'h00, 8'h00, 8'h00, 8'h00}, "clip0");
        drain();

        // Back-to-back stream with out_rdy low in cycles 3..6
        for (int i = 0; i < 8; i++) stream_d[i] = {$urandom(), $urandom()};
        sent = 0; c = 0; saw_low = 1'b0;
        while (sent < 8 && c < 60) begin
            drive(stream_d[sent], 1'b0, 4'd3, 7'd100);
            out_rdy = !(c >= 3 && c <= 6);
            cycle();
            if (last_in_hs) sent++;
            if (!last_in_rdy) saw_low = 1'b1;
            c++;
        end
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_in_rdy_low", 64'(saw_low), 64'd1);
        drain();

        // Randomized traffic and back-pressure
        in_vld = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!in_vld || last_in_hs) begin
                in_vld    = ($urandom_range(0, 3) != 0);
                in_data   = {$urandom(), $urandom()};
                cfg_relu  = 1'($urandom());
                cfg_shift = SHIFT_W'($urandom());
                cfg_clip  = ($urandom_range(0, 7) == 0) ? '0 : (DOUT_W-1)'($urandom());
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Reset with two beats in flight
        out_rdy = 1'b0;
        drive({16'h1234, 16'h0FFF, 16'h8001, 16'h0100}, 1'b0, 4'd1, 7'h7F);
        cycle();
        drive({16'h0555, 16'h0AAA, 16'hF00F, 16'h7000}, 1'b1, 4'd2, 7'h3F);
        cycle();
        in_vld = 1'b0;
        chk("flight_s2_full", 64'(out_vld), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst2_out_vld", 64'(out_vld), 64'd0);
        chk("rst2_out_data", 64'(out_data), 64'd0);
        chk("rst2_in_rdy", 64'(in_rdy), 64'd1);
        send_single({16'h0040, 16'hFFC0, 16'h0020, 16'h0000}, 1'b0, 4'd4, 7'h7F,
                    model({16'h0040, 16'hFFC0, 16'h0020, 16'h0000}, 1'b0, 4, 127), "post_rst");
        drain();

`ifdef RELU_QUANT_SAT_CNT_EN
        // Saturation counter: accumulate, clear-with-handshake, saturate
        sat_cnt_clr = 1'b1;
        cycle();
        sat_cnt_clr = 1'b0;
        chk("satcnt_clr", 64'(sat_cnt), 64'd0);
        for (int i = 0; i < 3; i++)
            send_single({4{16'h0100}}, 1'b0, 4'd0, 7'h00, {4'hF, 32'h0}, "satbeat");
        chk("satcnt_12", 64'(sat_cnt), 64'd12);
        drive({4{16'h0100}}, 1'b0, 4'd0, 7'h00);
        out_rdy = 1'b1;
        cycle();
        in_vld = 1'b0;
        cycle();
        sat_cnt_clr = 1'b1;
        cycle();
        sat_cnt_clr = 1'b0;
        chk("satcnt_clr_hs", 64'(sat_cnt), 64'd0);
        chk("satcnt_clr_hs_vld", 64'(last_out_hs), 64'd1);
        drive({4{16'h0100}}, 1'b0, 4'd0, 7'h00);
        out_rdy = 1'b1;
        for (int k = 0; k < 16400; k++) cycle();
        drain();
        chk("satcnt_sat", 64'(sat_cnt), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
